parity_frame_serializer: RTL and testbench
==========================================

// Module: parity_frame_serializer
// PURPOSE
//  Upstream feeder for the serial parity detector. Accepts a parallel word over a
//  valid/ready handshake and shifts it out LSB-first on a 1-bit serial line x,
//  then appends one parity bit. Frames can run back-to-back with no idle gap.
//  After every frame, the parity detector downstream sees a known parity state.
// PARAMETERS
//  WIDTH       8  data bits per frame; legal range >= 2
//  ODD_PARITY  0  0: even parity (ones in data+parity is even); 1: odd parity
//  IDLE_LEVEL  0  level driven on x when no frame is in progress
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  din        in   WIDTH  parallel word; sampled only on an accept
//  din_valid  in   1      din holds a word to send
//  din_ready  out  1      serializer can accept a word this cycle
//  x          out  1      serial output bit, registered
//  x_valid    out  1      x carries a frame bit (data, parity, or start bit)
//  last       out  1      high only while x carries the parity bit
//  busy       out  1      frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert use): state=IDLE, x=IDLE_LEVEL,
//    x_valid=0, last=0, busy=0, bit counter=0, shift reg=0, parity acc=0.
//    Since din_ready is decoded from state, din_ready=1 during reset.
//  - States: IDLE -> DATA -> PARITY -> (IDLE | DATA).
//  - din_ready = (state==IDLE) | (state==PARITY). Accept = din_valid & din_ready
//    at a posedge. On accept, din is loaded into the shift reg and the parity acc
//    is cleared.
//  - Latency: on the cycle after an accept, x = din[0] and x_valid = 1. Data bits
//    d[0]..d[WIDTH-1] occupy WIDTH consecutive cycles. The next cycle is PARITY:
//    x = ^din ^ ODD_PARITY, x_valid=1, last=1.
//  - Parity acc XORs each data bit as it is shifted. The parity bit is taken from
//    the acc, not recomputed from din. din may change freely after an accept.
//  - Bit counter width is $clog2(WIDTH). It counts 0..WIDTH-1 in DATA and leaves
//    DATA when count == WIDTH-1. It must not wrap into a spurious extra bit.
//  - If an accept happens during PARITY: next state is DATA with the new word.
//    There is no bubble, and x_valid stays 1 continuously.
//  - If there is no accept during PARITY: next state is IDLE, x=IDLE_LEVEL,
//    x_valid=0, last=0.
//  - din_valid asserted during DATA: din_ready=0, and the word is held by the
//    source (no drop). It is accepted at the PARITY cycle.
//  - rst_n asserted mid-frame: the frame is aborted immediately. No parity bit is
//    emitted, outputs go to reset values, and the partial frame is not resumed.
// CONFIGURATION
//  PAR_SER_START_BIT_EN (macro):
//   - When defined: adds a START state before DATA, emitting one bit of value
//     ~IDLE_LEVEL with x_valid=1, last=0. The frame is WIDTH+2 cycles. The start
//     bit is excluded from parity. A back-to-back accept in PARITY goes to START.
//   - When undefined: the START state is absent, and the frame is WIDTH+1 cycles.
// TESTING
//  1. rst_n=0 in the middle of the 4th data bit -> x=0, x_valid=0, last=0,
//     busy=0, din_ready=1 in the same cycle; after release, an idle line.
//  2. WIDTH=8, even, din=8'hB2 -> x = 0,1,0,0,1,1,0,1 then parity 0. last is
//     high on the 9th cycle only. With ODD_PARITY=1, the parity bit is 1.
//  3. din=8'h07, even -> data 1,1,1,0,0,0,0,0, parity 1. Feeding x into the
//     parity detector leaves its output at the even state after the frame.
//  4. din_valid held high with words 8'hFF then 8'h01 -> 18 contiguous x_valid
//     cycles. Parity bits are 0 then 1. The second accept occurs in the first
//     frame's last cycle.
//  5. Word presented at DATA bit 2 (din_ready=0) -> it is not accepted until the
//     PARITY cycle, then sent intact: no loss, no duplication.
//  6. With PAR_SER_START_BIT_EN defined, IDLE_LEVEL=0, din=8'hB2 -> 10-cycle frame:
//     1, then 0,1,0,0,1,1,0,1, then 0.

Source files
------------

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial frame source: WIDTH data bits LSB-first, then a parity bit.
// Define PAR_SER_START_BIT_EN to prefix each frame with a start bit of ~IDLE_LEVEL.
module parity_frame_serializer #(
   parameter int WIDTH      = 8,
   parameter bit ODD_PARITY = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PAR_SER_START_BIT_EN
   typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             acc;
   logic             accept;

   assign din_ready = (state == IDLE) || (state == PARITY);
   assign busy      = (state != IDLE);
   assign accept    = din_valid & din_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         acc     <= 1'b0;
         x       <= IDLE_LEVEL;
         x_valid <= 1'b0;
         last    <= 1'b0;
      end else begin
         unique case (state)
            IDLE, PARITY: begin
               last <= 1'b0;
               if (accept) begin
                  acc     <= 1'b0;
                  cnt     <= '0;
                  x_valid <= 1'b1;
`ifdef PAR_SER_START_BIT_EN
                  state   <= START;
                  x       <= ~IDLE_LEVEL;
                  shreg   <= din;
`else
                  state   <= DATA;
                  x       <= din[0];
                  shreg   <= din >> 1;
`endif
               end else begin
                  state   <= IDLE;
                  x       <= IDLE_LEVEL;
                  x_valid <= 1'b0;
               end
            end
`ifdef PAR_SER_START_BIT_EN
            START: begin
               state <= DATA;
               x     <= shreg[0];
               shreg <= shreg >> 1;
            end
`endif
            DATA: begin
               // acc folds in the bit currently on x as it leaves
               acc <= acc ^ x;
               if (cnt == LAST_CNT) begin
                  state <= PARITY;
                  x     <= acc ^ x ^ ODD_PARITY;
                  last  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + 1'b1;
                  x     <= shreg[0];
                  shreg <= shreg >> 1;
               end
            end
            default: begin
               state   <= IDLE;
               x       <= IDLE_LEVEL;
               x_valid <= 1'b0;
               last    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench for parity_frame_serializer: even and odd instances in lockstep.
// Honours PAR_SER_START_BIT_EN when the build defines it.
module tb_parity_frame_serializer;

   localparam int W = 8;
`ifdef PAR_SER_START_BIT_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         din_ready, x, x_valid, last, busy;
   logic         rdy2, x2, xv2, last2, busy2;
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   parity_frame_serializer #(
      .WIDTH(W), .ODD_PARITY(1'b0), .IDLE_LEVEL(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .x(x), .x_valid(x_valid),
      .last(last), .busy(busy)
   );

   parity_frame_serializer #(
      .WIDTH(W), .ODD_PARITY(1'b1), .IDLE_LEVEL(1'b0)
   ) dut_odd (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(rdy2), .x(x2), .x_valid(xv2),
      .last(last2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_x"}, {x2, x}, 8'h0);
      chk({tag, "_xv"}, {xv2, x_valid}, 8'h0);
      chk({tag, "_last"}, {last2, last}, 8'h0);
      chk({tag, "_busy"}, {busy2, busy}, 8'h0);
      chk({tag, "_rdy"}, {rdy2, din_ready}, 8'h3);
   endtask

   // Called one cycle after the accept edge; ends on the parity cycle.
   // At data bit pa a new word nw is offered while din_ready must be low.
   task automatic frame(input string tag, input logic [W-1:0] w,
                        input int pa, input logic [W-1:0] nw);
      logic pe, po;
      pe = 1'b0;
      po = 1'b0;
      if (SB) begin
         chk({tag, "_start"}, {x2, x}, 8'h3);
         chk({tag, "_start_v"}, {xv2, x_valid}, 8'h3);
         chk({tag, "_start_l"}, {last2, last}, 8'h0);
         step();
      end
      for (int i = 0; i < W; i++) begin
         chk($sformatf("%s_d%0d", tag, i), {x2, x}, {w[i], w[i]});
         chk($sformatf("%s_v%0d", tag, i), {xv2, x_valid}, 8'h3);
         chk($sformatf("%s_l%0d", tag, i), {last2, last}, 8'h0);
         pe ^= x;
         po ^= x2;
         if (i == pa) begin
            din = nw;
            din_valid = 1'b1;
            chk($sformatf("%s_rdy%0d", tag, i), {rdy2, din_ready}, 8'h0);
         end
         step();
      end
      chk({tag, "_par"}, {x2, x}, {(^w) ^ 1'b1, ^w});
      chk({tag, "_par_v"}, {xv2, x_valid}, 8'h3);
      chk({tag, "_par_l"}, {last2, last}, 8'h3);
      chk({tag, "_par_rdy"}, {rdy2, din_ready}, 8'h3);
      pe ^= x;
      po ^= x2;
      chk({tag, "_detector"}, {po, pe}, 8'h2);
   endtask

   initial begin
      #1;
      idle_chk("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      idle_chk("idle0");

      din = 8'hB2;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      din = 8'h00;
      frame("b2", 8'hB2, -1, 8'h00);
      step();
      idle_chk("after_b2");

      din = 8'h07;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      frame("07", 8'h07, -1, 8'h00);
      step();
      idle_chk("after_07");

      din = 8'hFF;
      din_valid = 1'b1;
      step();
      din = 8'h01;
      frame("ff", 8'hFF, -1, 8'h00);
      step();
      din_valid = 1'b0;
      din = 8'h00;
      frame("01", 8'h01, -1, 8'h00);
      step();
      idle_chk("after_01");

      din = 8'h5A;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      frame("5a", 8'h5A, 2, 8'h3C);
      step();
      din_valid = 1'b0;
      din = 8'h00;
      frame("3c", 8'h3C, -1, 8'h00);
      step();
      idle_chk("after_3c");
      step();
      idle_chk("no_dup");

      din = 8'hA8;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      if (SB) step();
      repeat (3) step();
      chk("abort_pre_x", {x2, x}, 8'h3);
      chk("abort_pre_busy", {busy2, busy}, 8'h3);
      #2;
      rst_n = 1'b0;
      #1;
      idle_chk("abort");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk($sformatf("post_abort_xv%0d", i), {xv2, x_valid}, 8'h0);
         chk($sformatf("post_abort_x%0d", i), {x2, x}, 8'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
